// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- serial receiver paired with the team's UART transmitter.
//
// Receives 8N1 frames (LSB first, idle high) on an asynchronous input and holds
// each received byte in a one-entry output register with a ready flag. It also
// reports overrun, framing and (optionally) parity errors.
//
// Build option:
//   RX_PARITY_EN  when defined, frames are 8E1. A PARITY state follows DATA and
//                 parity_err is live. When undefined, parity_err is tied to 0.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit (even, >= 4). Default 16.
//   SYNC_STAGES   flops in the rx synchroniser (>= 2). Default 2.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   rx           asynchronous serial input, idle high
//   rd           one-cycle read strobe; clears datardy and all error flags
//   data         last received byte, stable while datardy=1
//   datardy      high while data holds an unread byte
//   overrun      sticky: a frame completed while datardy=1
//   framing_err  sticky: a completed frame had stop bit = 0
//   parity_err   sticky parity mismatch (constant 0 without RX_PARITY_EN)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data,
    output logic       datardy,
    output logic       overrun,
    output logic       framing_err,
    output logic       parity_err
);

    localparam int SCNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [SCNT_W-1:0] BIT_LAST  = SCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Input synchroniser; resets to the idle level so reset never looks like a start bit.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_reg[SYNC_STAGES-1];

    // Frame state machine
    state_t              state_reg, state_next;
    logic [SCNT_W-1:0]   scnt_reg, scnt_next;
    logic [2:0]          idx_reg, idx_next;
    logic [7:0]          shift_reg, shift_next;
    logic                stop_reg, stop_next;   // sampled stop bit of the last frame
    logic                done_reg, done_next;   // one-cycle pulse: frame complete
`ifdef RX_PARITY_EN
    logic                par_reg, par_next;     // sampled parity bit
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            scnt_reg  <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            stop_reg  <= 1'b1;
            done_reg  <= 1'b0;
`ifdef RX_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            scnt_reg  <= scnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            stop_reg  <= stop_next;
            done_reg  <= done_next;
`ifdef RX_PARITY_EN
            par_reg   <= par_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        scnt_next  = scnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        stop_next  = stop_reg;
        done_next  = 1'b0;
`ifdef RX_PARITY_EN
        par_next   = par_reg;
`endif
        case (state_reg)
            IDLE: begin
                scnt_next = '0;
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                // Re-check the line at the middle of the start bit to reject glitches.
                if (scnt_reg == HALF_LAST) begin
                    scnt_next  = '0;
                    idx_next   = '0;
                    state_next = rxs ? IDLE : DATA;
                end else begin
                    scnt_next = scnt_reg + SCNT_ONE;
                end
            end
            DATA: begin
                if (scnt_reg == BIT_LAST) begin
                    scnt_next           = '0;
                    shift_next[idx_reg] = rxs;
                    idx_next            = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    scnt_next = scnt_reg + SCNT_ONE;
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (scnt_reg == BIT_LAST) begin
                    scnt_next  = '0;
                    par_next   = rxs;
                    state_next = STOP;
                end else begin
                    scnt_next = scnt_reg + SCNT_ONE;
                end
            end
`endif
            STOP: begin
                if (scnt_reg == BIT_LAST) begin
                    scnt_next  = '0;
                    stop_next  = rxs;
                    done_next  = 1'b1;
                    // A low stop bit may be a break; wait for the line to go high.
                    state_next = rxs ? IDLE : BREAK;
                end else begin
                    scnt_next = scnt_reg + SCNT_ONE;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Host-side output register and sticky flags.
    // A completing frame beats a simultaneous read; rd then only suppresses
    // overrun and makes the flags reflect the new frame alone.
    logic [7:0] data_reg;
    logic       datardy_reg;
    logic       overrun_reg;
    logic       framing_reg;
`ifdef RX_PARITY_EN
    logic       parity_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg    <= 8'h00;
            datardy_reg <= 1'b0;
            overrun_reg <= 1'b0;
            framing_reg <= 1'b0;
`ifdef RX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else if (done_reg) begin
            data_reg    <= shift_reg;
            datardy_reg <= 1'b1;
            overrun_reg <= rd ? 1'b0 : (overrun_reg | datardy_reg);
            framing_reg <= (rd ? 1'b0 : framing_reg) | ~stop_reg;
`ifdef RX_PARITY_EN
            parity_reg  <= (rd ? 1'b0 : parity_reg) | (^{shift_reg, par_reg});
`endif
        end else if (rd) begin
            datardy_reg <= 1'b0;
            overrun_reg <= 1'b0;
            framing_reg <= 1'b0;
`ifdef RX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end
    end

    assign data        = data_reg;
    assign datardy     = datardy_reg;
    assign overrun     = overrun_reg;
    assign framing_err = framing_reg;
`ifdef RX_PARITY_EN
    assign parity_err  = parity_reg;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx.
// Drives serial frames on rx from the bench side and compares the host-side
// outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int SS  = 2;
`ifdef RX_PARITY_EN
    localparam int LAT = SS + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = SS + CPB / 2 + 9 * CPB + 1;
`endif

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd;
    logic [7:0] data;
    logic       datardy;
    logic       overrun;
    logic       framing_err;
    logic       parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd         (rd),
        .data       (data),
        .datardy    (datardy),
        .overrun    (overrun),
        .framing_err(framing_err),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // All drives happen 1 time unit after a rising edge.
    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
`ifdef RX_PARITY_EN
        rx = par;
        wait_bit();
`endif
        rx = stop;
        wait_bit();
        $display("frame sent: byte %02h stop %0b par %0b -> data %02h rdy %0b ovr %0b fe %0b pe %0b",
                 b, stop, par, data, datardy, overrun, framing_err, parity_err);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        rd    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("reset_data",    32'(data),        32'h00);
        check("reset_datardy", 32'(datardy),     32'h0);
        check("reset_overrun", 32'(overrun),     32'h0);
        check("reset_framing", 32'(framing_err), 32'h0);
        check("reset_parity",  32'(parity_err),  32'h0);
        wait_bit();

        // Nominal frame with latency measurement
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                cyc = 0;
                while (!datardy && cyc < 400) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
            end
        join
        check("nominal_latency", 32'(cyc - 1), 32'(LAT));
        check("nominal_data",    32'(data),        32'hA5);
        check("nominal_datardy", 32'(datardy),     32'h1);
        check("nominal_overrun", 32'(overrun),     32'h0);
        check("nominal_framing", 32'(framing_err), 32'h0);
        check("nominal_parity",  32'(parity_err),  32'h0);
        pulse_rd();
        check("read_clears_rdy", 32'(datardy), 32'h0);
        check("read_keeps_data", 32'(data),    32'hA5);
        pulse_rd();
        check("idle_read_noop",  32'(datardy), 32'h0);

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3) wait_bit();
        $display("glitch: rdy %0b ovr %0b fe %0b", datardy, overrun, framing_err);
        check("glitch_datardy", 32'(datardy),     32'h0);
        check("glitch_framing", 32'(framing_err), 32'h0);
        check("glitch_overrun", 32'(overrun),     32'h0);

        // Overrun with back-to-back frames (no idle bit between them)
        send_frame(8'h3C, 1'b1, 1'b0);
        check("ovr_first_data",    32'(data),    32'h3C);
        check("ovr_first_overrun", 32'(overrun), 32'h0);
        send_frame(8'hC3, 1'b1, 1'b0);
        check("ovr_data",    32'(data),    32'hC3);
        check("ovr_datardy", 32'(datardy), 32'h1);
        check("ovr_overrun", 32'(overrun), 32'h1);
        pulse_rd();
        check("ovr_cleared",     32'(overrun), 32'h0);
        check("ovr_rdy_cleared", 32'(datardy), 32'h0);

        // Framing error followed by a long break
        send_frame(8'h55, 1'b0, 1'b0);
        check("fe_data",    32'(data),        32'h55);
        check("fe_flag",    32'(framing_err), 32'h1);
        check("fe_datardy", 32'(datardy),     32'h1);
        pulse_rd();
        check("fe_cleared", 32'(framing_err), 32'h0);
        repeat (40) wait_bit();
        check("break_no_retrigger", 32'(datardy), 32'h0);
        rx = 1'b1;
        repeat (2) wait_bit();
        check("break_release_rdy", 32'(datardy), 32'h0);
        send_frame(8'h96, 1'b1, 1'b0);
        check("post_break_data",    32'(data),        32'h96);
        check("post_break_framing", 32'(framing_err), 32'h0);

        // Read strobe in the exact completion cycle of a second frame
        fork
            send_frame(8'h81, 1'b1, 1'b0);
            begin
                repeat (LAT) @(posedge clk);
                #1;
                rd = 1'b1;
                @(posedge clk);
                #1;
                rd = 1'b0;
            end
        join
        check("simul_data",    32'(data),    32'h81);
        check("simul_datardy", 32'(datardy), 32'h1);
        check("simul_overrun", 32'(overrun), 32'h0);

        // Reset during data bit 4 of 8'h5A abandons that frame
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            rx = (i == 1 || i == 3) ? 1'b1 : 1'b0;
            wait_bit();
        end
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("mid-frame reset: data %02h rdy %0b", data, datardy);
        check("midrst_datardy", 32'(datardy), 32'h0);
        check("midrst_data",    32'(data),    32'h00);
        repeat (3) wait_bit();
        check("midrst_idle_rdy", 32'(datardy), 32'h0);
        send_frame(8'h0F, 1'b1, 1'b0);
        check("midrst_new_data", 32'(data),        32'h0F);
        check("midrst_new_rdy",  32'(datardy),     32'h1);
        check("midrst_new_ovr",  32'(overrun),     32'h0);
        check("midrst_new_fe",   32'(framing_err), 32'h0);
        check("midrst_new_pe",   32'(parity_err),  32'h0);
        pulse_rd();

`ifdef RX_PARITY_EN
        // 8'h07 has three ones, so even parity needs a 1
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_bad_data", 32'(data),       32'h07);
        check("par_bad_flag", 32'(parity_err), 32'h1);
        pulse_rd();
        check("par_cleared",  32'(parity_err), 32'h0);
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_good_flag", 32'(parity_err), 32'h0);
        check("par_good_rdy",  32'(datardy),    32'h1);
        pulse_rd();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
